// File: rtl/median_rank_filter.sv
// Rank-order filter: loads N samples, bubble-sorts in place with one
// compare-exchange unit, and returns the median, minimum or maximum.
module median_rank_filter #(
    parameter int WIDTH = 8,
    parameter int N     = 9
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] DI,
    input  logic             DSI,
    input  logic [1:0]       MODE,
    output logic [WIDTH-1:0] DO,
    output logic             DSO,
    output logic             RDY
);
    localparam int CW  = $clog2(N + 1);
    localparam int IW  = $clog2(N);
    localparam int MID = (N - 1) / 2;

    typedef enum logic [1:0] {LOAD, SORT, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] r [N];
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx1;
    logic [IW-1:0]    pass;
    logic [IW-1:0]    last_pass;
    logic [IW-1:0]    last_idx;
    logic [1:0]       mode_q;
    logic             full;
    logic             pass_end;
    logic             swap;

    // Pass p bubbles the (p+1)-th largest value up to R[N-1-p].
    always_comb begin
        unique case (mode_q)
            2'b01:   last_pass = IW'(N - 2);
            2'b10:   last_pass = '0;
            default: last_pass = IW'(MID);
        endcase
    end

    assign idx1     = idx + 1'b1;
    assign last_idx = IW'(N - 2) - pass;
    assign pass_end = (idx == last_idx);
    assign swap     = r[idx] > r[idx1];
    assign full     = (cnt == CW'(N - 1));

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD: if (DSI && full) state_nx = SORT;
            SORT: if (pass_end && pass == last_pass) state_nx = DONE;
            DONE: state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= LOAD;
        else        state <= state_nx;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            idx    <= '0;
            pass   <= '0;
            mode_q <= '0;
            DO     <= '0;
            DSO    <= 1'b0;
            RDY    <= 1'b1;
            for (int k = 0; k < N; k++) r[k] <= '0;
        end else begin
            DSO <= 1'b0;
            RDY <= (state_nx == LOAD);
            unique case (state)
                LOAD: begin
                    if (DSI) begin
                        for (int k = 0; k < N - 1; k++) r[k] <= r[k+1];
                        r[N-1] <= DI;
                        if (cnt == '0) mode_q <= MODE;
                        cnt  <= full ? '0 : cnt + 1'b1;
                        idx  <= '0;
                        pass <= '0;
                    end
                end
                SORT: begin
                    if (swap) begin
                        r[idx]  <= r[idx1];
                        r[idx1] <= r[idx];
                    end
                    if (pass_end) begin
                        idx  <= '0;
                        pass <= pass + 1'b1;
                    end else begin
                        idx <= idx1;
                    end
                end
                DONE: begin
                    DSO <= 1'b1;
                    unique case (mode_q)
                        2'b01:   DO <= r[0];
                        2'b10:   DO <= r[N-1];
                        default: DO <= r[MID];
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_median_rank_filter.sv
// Bench for median_rank_filter: three instances (N=9/W=8, N=3/W=8,
// N=5/W=12) checked every cycle against a sorting model plus literals.
module tb_median_rank_filter;
    logic        CLK = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] di_v   [3];
    logic        dsi_v  [3];
    logic [1:0]  mode_v [3];
    logic [7:0]  do0, do1;
    logic [11:0] do2;
    logic        dso0, dso1, dso2;
    logic        rdy0, rdy1, rdy2;

    int checks   = 0;
    int failures = 0;

    int unsigned m_win [3][32];
    int          m_cnt [3];
    int          m_cd  [3];
    bit          m_rdy [3];
    bit          m_dso [3];
    int unsigned m_do  [3];
    int unsigned m_res [3];
    logic [1:0]  m_mode[3];

    always #5 CLK = ~CLK;

    median_rank_filter #(.WIDTH(8), .N(9)) u0 (
        .CLK(CLK), .reset(rst_n), .DI(di_v[0][7:0]), .DSI(dsi_v[0]),
        .MODE(mode_v[0]), .DO(do0), .DSO(dso0), .RDY(rdy0));
    median_rank_filter #(.WIDTH(8), .N(3)) u1 (
        .CLK(CLK), .reset(rst_n), .DI(di_v[1][7:0]), .DSI(dsi_v[1]),
        .MODE(mode_v[1]), .DO(do1), .DSO(dso1), .RDY(rdy1));
    median_rank_filter #(.WIDTH(12), .N(5)) u2 (
        .CLK(CLK), .reset(rst_n), .DI(di_v[2][11:0]), .DSI(dsi_v[2]),
        .MODE(mode_v[2]), .DO(do2), .DSO(dso2), .RDY(rdy2));

    function automatic int nsz(int i);
        case (i)
            0: return 9;
            1: return 3;
            default: return 5;
        endcase
    endfunction

    function automatic int unsigned get_do(int i);
        case (i)
            0: return {24'd0, do0};
            1: return {24'd0, do1};
            default: return {20'd0, do2};
        endcase
    endfunction

    function automatic bit get_dso(int i);
        case (i)
            0: return dso0;
            1: return dso1;
            default: return dso2;
        endcase
    endfunction

    function automatic bit get_rdy(int i);
        case (i)
            0: return rdy0;
            1: return rdy1;
            default: return rdy2;
        endcase
    endfunction

    // Model: rank of the sorted window, chosen by the latched mode.
    function automatic int unsigned rank(int i);
        int unsigned a[32];
        int unsigned t;
        int n = nsz(i);
        for (int k = 0; k < n; k++) a[k] = m_win[i][k];
        for (int x = 1; x < n; x++)
            for (int y = x; y > 0 && a[y-1] > a[y]; y--) begin
                t = a[y]; a[y] = a[y-1]; a[y-1] = t;
            end
        case (m_mode[i])
            2'b01:   return a[0];
            2'b10:   return a[n-1];
            default: return a[(n-1)/2];
        endcase
    endfunction

    function automatic int cycles(int i);
        int n = nsz(i);
        int p_n;
        int c = 0;
        case (m_mode[i])
            2'b01:   p_n = n - 1;
            2'b10:   p_n = 1;
            default: p_n = (n + 1) / 2;
        endcase
        for (int p = 0; p < p_n; p++) c += n - 1 - p;
        return c;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_cd[i] = 0; m_rdy[i] = 1'b1;
            m_dso[i] = 1'b0; m_do[i] = 0; m_res[i] = 0; m_mode[i] = 2'b00;
        end
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                for (int i = 0; i < 3; i++) begin
                    m_dso[i] = 1'b0;
                    if (m_rdy[i]) begin
                        if (dsi_v[i]) begin
                            if (m_cnt[i] == 0) m_mode[i] = mode_v[i];
                            m_win[i][m_cnt[i]] = di_v[i];
                            m_cnt[i]++;
                            if (m_cnt[i] == nsz(i)) begin
                                m_res[i] = rank(i);
                                m_cd[i]  = cycles(i) + 1;
                                m_rdy[i] = 1'b0;
                                m_cnt[i] = 0;
                            end
                        end
                    end else begin
                        m_cd[i]--;
                        if (m_cd[i] == 0) begin
                            m_dso[i] = 1'b1;
                            m_do[i]  = m_res[i];
                            m_rdy[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(string nm, int unsigned act, int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("cmp_do%0d", i), get_do(i), m_do[i]);
                chk($sformatf("cmp_dso%0d", i), 32'(get_dso(i)), 32'(m_dso[i]));
                chk($sformatf("cmp_rdy%0d", i), 32'(get_rdy(i)), 32'(m_rdy[i]));
            end
        end
    end

    task automatic send(int inst, int unsigned v, logic [1:0] md, int gaps,
                        output bit acc_dso, output int unsigned acc_do);
        int n = 0;
        repeat (gaps) begin
            @(negedge CLK);
            dsi_v[inst] = 1'b0;
        end
        @(negedge CLK);
        di_v[inst]   = v;
        mode_v[inst] = md;
        dsi_v[inst]  = 1'b1;
        while (!get_rdy(inst) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL send_timeout inst=%0d actual=busy required=ready", inst);
        end
        acc_dso = get_dso(inst);
        acc_do  = get_do(inst);
    endtask

    task automatic wait_res(string nm, int inst, int unsigned exp, int lat, bit pulse);
        int n   = 0;
        int low = 0;
        bit got = 1'b0;
        while (n < 200) begin
            @(negedge CLK);
            n++;
            if (!get_rdy(inst)) low++;
            if (get_dso(inst)) begin
                dsi_v[inst] = 1'b0;
                got = 1'b1;
                break;
            end
            di_v[inst]  = 0;
            dsi_v[inst] = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        dsi_v[inst] = 1'b0;
        chk({nm, "_dso"}, 32'(got), 1);
        chk({nm, "_do"}, get_do(inst), exp);
        chk({nm, "_lat"}, n, lat);
        chk({nm, "_rdylow"}, low, lat - 1);
        @(negedge CLK);
        chk({nm, "_dso1cyc"}, 32'(get_dso(inst)), 0);
    endtask

    task automatic win(string nm, int inst, int unsigned s[9], logic [1:0] md,
                       logic [1:0] md2, int gmax, bit pulse, int unsigned exp, int lat);
        bit ad;
        int unsigned ado;
        for (int k = 0; k < nsz(inst); k++)
            send(inst, s[k], (k == 0) ? md : md2, $urandom_range(0, gmax), ad, ado);
        wait_res(nm, inst, exp, lat, pulse);
    endtask

    int unsigned base[9] = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    int unsigned tens[9] = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
    int unsigned mix[9]  = '{30, 90, 10, 70, 50, 20, 80, 40, 60};

    initial begin
        bit ad;
        int unsigned ado;
        for (int i = 0; i < 3; i++) begin
            di_v[i] = 0; dsi_v[i] = 1'b0; mode_v[i] = 2'b00;
        end
        #1 rst_n = 1'b0;
        #11;
        chk("reset_do", get_do(0), 0);
        chk("reset_dso", 32'(dso0), 0);
        chk("reset_rdy", 32'(rdy0), 1);
        #10 rst_n = 1'b1;

        win("med", 0, base, 2'b00, 2'b00, 0, 1'b0, 5, 32);
        win("max", 0, base, 2'b10, 2'b10, 0, 1'b0, 9, 10);
        win("min", 0, base, 2'b01, 2'b01, 0, 1'b0, 1, 38);
        win("med11", 0, base, 2'b11, 2'b11, 0, 1'b0, 5, 32);
        win("modelatch", 0, base, 2'b10, 2'b01, 0, 1'b0, 9, 10);
        win("dups", 0, '{7, 7, 7, 3, 3, 3, 200, 200, 200}, 2'b00, 2'b00, 0, 1'b0, 7, 32);
        win("all255", 0, '{255, 255, 255, 255, 255, 255, 255, 255, 255},
            2'b00, 2'b00, 0, 1'b0, 255, 32);
        win("zeros_med", 0, '{0, 0, 0, 0, 255, 0, 0, 0, 0}, 2'b00, 2'b00, 0, 1'b0, 0, 32);
        win("zeros_max", 0, '{0, 0, 0, 0, 255, 0, 0, 0, 0}, 2'b10, 2'b10, 0, 1'b0, 255, 10);
        win("gaps", 0, base, 2'b00, 2'b00, 3, 1'b0, 5, 32);
        win("pulse", 0, base, 2'b00, 2'b00, 0, 1'b1, 5, 32);

        for (int k = 0; k < 9; k++) send(0, base[k], 2'b00, 0, ad, ado);
        send(0, tens[0], 2'b00, 0, ad, ado);
        chk("b2b_acc_dso", 32'(ad), 1);
        chk("b2b_acc_do", ado, 5);
        for (int k = 1; k < 9; k++) send(0, tens[k], 2'b00, 0, ad, ado);
        wait_res("b2b_w2", 0, 50, 32, 1'b0);

        for (int k = 0; k < 9; k++) send(0, base[k], 2'b01, 0, ad, ado);
        repeat (10) begin
            @(negedge CLK);
            dsi_v[0] = 1'b0;
        end
        chk("midsort_rdy", 32'(rdy0), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_do", get_do(0), 0);
        chk("rst_dso", 32'(dso0), 0);
        chk("rst_rdy", 32'(rdy0), 1);
        @(negedge CLK);
        #2 rst_n = 1'b1;
        win("after_rst", 0, mix, 2'b00, 2'b00, 0, 1'b0, 50, 32);

        win("n3_med", 1, '{5, 1, 3, 0, 0, 0, 0, 0, 0}, 2'b00, 2'b00, 0, 1'b0, 3, 5);
        win("n3_max", 1, '{5, 1, 3, 0, 0, 0, 0, 0, 0}, 2'b10, 2'b10, 0, 1'b0, 5, 4);
        win("n3_min", 1, '{5, 1, 3, 0, 0, 0, 0, 0, 0}, 2'b01, 2'b01, 1, 1'b0, 1, 5);
        win("n5_med", 2, '{4000, 100, 2500, 4095, 7, 0, 0, 0, 0},
            2'b00, 2'b00, 0, 1'b0, 2500, 11);
        win("n5_min", 2, '{4000, 100, 2500, 4095, 7, 0, 0, 0, 0},
            2'b01, 2'b01, 2, 1'b1, 7, 12);
        win("n5_max", 2, '{4000, 100, 2500, 4095, 7, 0, 0, 0, 0},
            2'b10, 2'b10, 0, 1'b0, 4095, 6);

        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
